wb_seq_mult: RTL and testbench
==============================

# wb_seq_mult

Parametrised, Wishbone-mapped iterative multiplier for the Caravel user area. It extends the fixed binary-multiplier peripheral with:
- configurable operand width
- signed/unsigned mode
- a busy/done status handshake
- a software-selectable result slice driven to the DAC pins

It sits behind the project wrapper on the Caravel Wishbone slave bus and produces one product every WIDTH+1 cycles.

## Interface
Parameters:
- BASE_ADDRESS, 32'h3000_0000: 256-byte-aligned base of the register window.
- WIDTH, 16: operand width, legal range 2..32. The product is 2*WIDTH bits.
- OUT_W, 7: width of the DAC output slice.

Ports (clock and reset first):
- caravel_wb_clk_i, in, 1: single clock; all logic is rising-edge.
- caravel_wb_rst_i, in, 1: reset, asynchronous and active-high.
- caravel_wb_stb_i, in, 1: Wishbone strobe.
- caravel_wb_cyc_i, in, 1: Wishbone cycle.
- caravel_wb_we_i, in, 1: Wishbone write enable.
- caravel_wb_sel_i, in, 4: Wishbone byte lane select.
- caravel_wb_dat_i, in, 32: Wishbone write data.
- caravel_wb_adr_i, in, 32: Wishbone byte address.
- caravel_wb_ack_o, out, 1: Wishbone acknowledge.
- caravel_wb_dat_o, out, 32: Wishbone read data.
- be_out, out, OUT_W: result slice driven to the DAC.
- busy_o, out, 1: multiplication in progress.
- done_o, out, 1: one-cycle pulse when a result is committed.

## Operation
- **Address decode.** An access is selected when cyc & stb are high and adr[31:8] == BASE_ADDRESS[31:8]. Unselected accesses are never acked.
- **Register map.** Offsets are adr[7:2]:
  - 0x00 OPA, rw, WIDTH bits.
  - 0x04 OPB, rw, WIDTH bits.
  - 0x08 CTRL, rw:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 SIGNED.
    - bits[13:8] SLICE: bit offset for be_out.
  - 0x0C STATUS, ro:
    - bit0 BUSY.
    - bit1 DONE, sticky.
  - 0x10 RES_LO: product[31:0].
  - 0x14 RES_HI: product[2*WIDTH-1:32], zero-extended. Reads 0 when WIDTH ≤ 16.
  - Other offsets in the window: ack, read 0, writes ignored.
- **Writes.**
  - Byte lanes are honoured for OPA, OPB and CTRL[13:8].
  - CTRL[1:0] is written only when sel[0] is set.
  - Register bits above WIDTH read 0.
- **State machine.** Three states: IDLE, RUN, FIX.
  - **IDLE.** A START write latches OPA, OPB and SIGNED into working registers and clears DONE.
    - In signed mode the latched operands are replaced by their magnitudes and the result sign is sign(A) XOR sign(B).
    - Next state is RUN with counter = 0.
  - **RUN.** Each cycle is one shift-add step on the multiplier LSB into a 2*WIDTH accumulator.
    - The counter increments each cycle. After WIDTH steps the state moves to FIX.
  - **FIX.** The accumulator, negated when the result sign is set, is committed to the result register.
    - DONE is set, done_o pulses for one cycle, and the state returns to IDLE.
- **While BUSY (RUN or FIX):**
  - Writes to OPA, OPB and CTRL are acked but ignored, including START.
  - RES reads return the previous committed result.
- **Signed edge cases.** The most negative operand (−2^(WIDTH−1)) is handled exactly: its magnitude fits in WIDTH unsigned bits. The product is taken modulo 2^(2*WIDTH).
- **be_out.** be_out = (result >> SLICE)[OUT_W-1:0]. Bits shifted in above 2*WIDTH are 0. be_out updates only on commit or on a SLICE write.
- **Reset.** Reset is asserted asynchronously and may arrive at any time, including mid-RUN. It forces the following; the in-flight product is discarded:
  - state = IDLE.
  - All registers, the result, ack, dat_o, be_out, busy_o and done_o = 0.

## Timing
- **Ack.**
  - caravel_wb_ack_o rises on the cycle after a selected access is sampled.
  - It is high for exactly one cycle.
  - It is low on the following cycle even if stb is still high, so there is no back-to-back ack without stb being resampled.
  - Read data is valid in the ack cycle.
- **START and BUSY.**
  - START is sampled on the edge at which ack is raised.
  - busy_o and STATUS.BUSY are high from the next cycle.
- **Latency.**
  - RUN lasts exactly WIDTH cycles and FIX lasts 1 cycle.
  - done_o asserts WIDTH+1 cycles after the first busy cycle.
  - busy_o falls in the same cycle that done_o is high.
- **Back-to-back.** A START accepted in the done_o cycle or later begins a new operation. No idle gap is required beyond the Wishbone ack cycle.

## Test plan
- **Unsigned maximum.** WIDTH=16, SIGNED=0, OPA=0xFFFF, OPB=0xFFFF, START.
  - done_o exactly 17 cycles after busy rises.
  - RES_LO = 0xFFFE0001, RES_HI = 0.
- **Signed negative results.** SIGNED=1, OPA=0xFFFD (−3), OPB=0x0005, START.
  - RES_LO = 0xFFFFFFF1.
  - Repeat with OPA=0x8000, OPB=0x8000: RES_LO = 0x40000000.
- **Busy protection.** Start 0x0003×0x0004. While busy, write OPA=0x00FF and START=1.
  - Both writes are acked.
  - The result is 0x0000000C.
  - OPA reads back 0x0003.
  - Only one done_o pulse occurs.
- **Reset mid-operation.** Assert caravel_wb_rst_i during RUN, cycle 5.
  - busy_o, be_out and all registers read 0 immediately.
  - After release, a new 0x0002×0x0003 yields 6.
- **Decode and ack.**
  - Access to 0x3000_0100: no ack.
  - Read of offset 0x20: ack after 1 cycle, data 0.
  - Holding stb high for 3 cycles: ack for one cycle only.
- **DAC slice.** Product 0x0000_1F80, SLICE=7.
  - be_out = 0x3F.
  - Change SLICE to 0: be_out = 0x00 one cycle after ack.

Source files
------------

// File: rtl/wb_seq_mult.sv
// Wishbone-mapped shift-add multiplier that produces one product every WIDTH+1 cycles.
// Signed operands are multiplied as magnitudes and the sign is restored on commit.
module wb_seq_mult #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          WIDTH        = 16,
    parameter int          OUT_W        = 7
) (
    input  logic             caravel_wb_clk_i,
    input  logic             caravel_wb_rst_i,
    input  logic             caravel_wb_stb_i,
    input  logic             caravel_wb_cyc_i,
    input  logic             caravel_wb_we_i,
    input  logic [3:0]       caravel_wb_sel_i,
    input  logic [31:0]      caravel_wb_dat_i,
    input  logic [31:0]      caravel_wb_adr_i,
    output logic             caravel_wb_ack_o,
    output logic [31:0]      caravel_wb_dat_o,
    output logic [OUT_W-1:0] be_out,
    output logic             busy_o,
    output logic             done_o
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] OFF_OPA    = 6'h00;
    localparam logic [5:0] OFF_OPB    = 6'h01;
    localparam logic [5:0] OFF_CTRL   = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;
    localparam logic [5:0] OFF_RES_LO = 6'h04;
    localparam logic [5:0] OFF_RES_HI = 6'h05;

    logic [1:0]       state;
    logic [5:0]       cnt;
    logic [5:0]       slice;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    result;
    logic             signed_mode;
    logic             neg;
    logic             done_flag;
    logic             held;

    logic             req;
    logic             access;
    logic             idle;
    logic             wr;
    logic             start;
    logic [5:0]       offset;
    logic [31:0]      lane_mask;
    logic [31:0]      rdata;
    logic [63:0]      result64;
    logic [WIDTH-1:0] opa_mag;
    logic [WIDTH-1:0] opb_mag;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    res_fix;
    logic             unused_adr;

    function automatic logic [OUT_W-1:0] take_slice(input logic [PW-1:0] value,
                                                     input logic [5:0]    shift);
        logic [PW+OUT_W-1:0] wide;
        wide = {{OUT_W{1'b0}}, value} >> shift;
        return wide[OUT_W-1:0];
    endfunction

    assign req = caravel_wb_cyc_i & caravel_wb_stb_i
               & (caravel_wb_adr_i[31:8] == BASE_ADDRESS[31:8]);
    // A strobe held past its ack must drop before another access is taken.
    assign access     = req & ~caravel_wb_ack_o & ~held;
    assign idle       = (state == S_IDLE);
    assign offset     = caravel_wb_adr_i[7:2];
    assign wr         = access & caravel_wb_we_i & idle;
    assign start      = wr & (offset == OFF_CTRL) & caravel_wb_sel_i[0] & caravel_wb_dat_i[0];
    assign busy_o     = ~idle;
    assign lane_mask  = {{8{caravel_wb_sel_i[3]}}, {8{caravel_wb_sel_i[2]}},
                         {8{caravel_wb_sel_i[1]}}, {8{caravel_wb_sel_i[0]}}};
    assign result64   = 64'(result);
    assign unused_adr = ^caravel_wb_adr_i[1:0];

    // The most negative operand negates to itself, which is its exact unsigned magnitude.
    assign opa_mag  = (caravel_wb_dat_i[1] && opa[WIDTH-1]) ? -opa : opa;
    assign opb_mag  = (caravel_wb_dat_i[1] && opb[WIDTH-1]) ? -opb : opb;
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign res_fix  = neg ? -acc : acc;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_OPA:    rdata = 32'(opa);
            OFF_OPB:    rdata = 32'(opb);
            OFF_CTRL:   rdata = {18'd0, slice, 6'd0, signed_mode, 1'b0};
            OFF_STATUS: rdata = {30'd0, done_flag, busy_o};
            OFF_RES_LO: rdata = result64[31:0];
            OFF_RES_HI: rdata = result64[63:32];
            default:    rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
        if (caravel_wb_rst_i) begin
            caravel_wb_ack_o <= 1'b0;
            caravel_wb_dat_o <= '0;
            held             <= 1'b0;
        end else begin
            caravel_wb_ack_o <= access;
            held             <= req & (caravel_wb_ack_o | held);
            caravel_wb_dat_o <= (access & ~caravel_wb_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
        if (caravel_wb_rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            slice       <= '0;
            opa         <= '0;
            opb         <= '0;
            mplier      <= '0;
            mcand       <= '0;
            acc         <= '0;
            result      <= '0;
            signed_mode <= 1'b0;
            neg         <= 1'b0;
            done_flag   <= 1'b0;
            done_o      <= 1'b0;
            be_out      <= '0;
        end else begin
            done_o <= 1'b0;
            if (wr) begin
                case (offset)
                    OFF_OPA: opa <= WIDTH'((32'(opa) & ~lane_mask) | (caravel_wb_dat_i & lane_mask));
                    OFF_OPB: opb <= WIDTH'((32'(opb) & ~lane_mask) | (caravel_wb_dat_i & lane_mask));
                    OFF_CTRL: begin
                        if (caravel_wb_sel_i[0]) signed_mode <= caravel_wb_dat_i[1];
                        if (caravel_wb_sel_i[1]) begin
                            slice  <= caravel_wb_dat_i[13:8];
                            be_out <= take_slice(result, caravel_wb_dat_i[13:8]);
                        end
                    end
                    default: ;
                endcase
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        acc       <= '0;
                        mcand     <= PW'(opa_mag);
                        mplier    <= opb_mag;
                        neg       <= caravel_wb_dat_i[1] & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        done_flag <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (cnt == 6'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    result    <= res_fix;
                    be_out    <= take_slice(res_fix, slice);
                    done_flag <= 1'b1;
                    done_o    <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_seq_mult.sv
// Self-checking bench for wb_seq_mult: a cycle-level reference model driven by the bus
// tasks, one per-cycle compare process, and directed vectors with literal expectations.
module tb_wb_seq_mult;

    localparam int          W    = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = '0;
    logic [31:0] adr = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [6:0]  be_out;
    logic        busy_o;
    logic        done_o;

    int checks     = 0;
    int failures   = 0;
    int cycle_no   = 0;
    int done_seen  = 0;

    // Reference model state.
    logic [15:0] m_opa    = '0;
    logic [15:0] m_opb    = '0;
    logic        m_signed = 1'b0;
    logic [5:0]  m_slice  = '0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;
    logic        m_done   = 1'b0;
    int          m_start  = -1000;

    wb_seq_mult #(.BASE_ADDRESS(BASE), .WIDTH(W), .OUT_W(7)) dut (
        .caravel_wb_clk_i (clk),
        .caravel_wb_rst_i (rst),
        .caravel_wb_stb_i (stb),
        .caravel_wb_cyc_i (cyc),
        .caravel_wb_we_i  (we),
        .caravel_wb_sel_i (sel),
        .caravel_wb_dat_i (dat),
        .caravel_wb_adr_i (adr),
        .caravel_wb_ack_o (ack),
        .caravel_wb_dat_o (dat_o),
        .be_out           (be_out),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy_at(input int n);
        return (n >= m_start) && (n <= m_start + W);
    endfunction

    function automatic logic [31:0] m_product(input logic [15:0] a, input logic [15:0] b,
                                              input logic s);
        longint      sa, sb, p;
        logic [63:0] pv;
        sa = a;
        sb = b;
        if (s && a[15]) sa = sa - 65536;
        if (s && b[15]) sb = sb - 65536;
        p  = sa * sb;
        pv = p;
        return pv[31:0];
    endfunction

    function automatic logic [6:0] m_dac(input logic [31:0] r, input logic [5:0] s);
        logic [63:0] w;
        w = {32'd0, r} >> s;
        return w[6:0];
    endfunction

    function automatic logic [15:0] m_merge(input logic [15:0] old, input logic [31:0] d,
                                            input logic [3:0] s);
        logic [31:0] v;
        v = {16'd0, old};
        for (int i = 0; i < 4; i++) if (s[i]) v[i*8 +: 8] = d[i*8 +: 8];
        return v[15:0];
    endfunction

    // Applies an acked access sampled at edge n to the model; returns the expected read data.
    task automatic m_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int n, output logic [31:0] exp_rd);
        bit busy_prev;
        busy_prev = m_busy_at(n - 1);
        case (a[7:2])
            6'h00:   exp_rd = {16'd0, m_opa};
            6'h01:   exp_rd = {16'd0, m_opb};
            6'h02:   exp_rd = {18'd0, m_slice, 6'd0, m_signed, 1'b0};
            6'h03:   exp_rd = {30'd0, m_done, busy_prev};
            6'h04:   exp_rd = m_result;
            default: exp_rd = '0;
        endcase
        if (w && !busy_prev) begin
            case (a[7:2])
                6'h00: m_opa = m_merge(m_opa, d, s);
                6'h01: m_opb = m_merge(m_opb, d, s);
                6'h02: begin
                    if (s[1]) m_slice = d[13:8];
                    if (s[0]) begin
                        m_signed = d[1];
                        if (d[0]) begin
                            m_start = n;
                            m_pend  = m_product(m_opa, m_opb, d[1]);
                            m_done  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic m_reset();
        m_opa = '0; m_opb = '0; m_signed = 1'b0; m_slice = '0;
        m_result = '0; m_pend = '0; m_done = 1'b0; m_start = -1000;
    endtask

    // One bus access; lat is the number of cycles until ack, or -1 if none arrived.
    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic [31:0] ex,
                      output int lat);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        rd = '0; ex = '0; n = 0; lat = -1;
        while (n < 8 && lat < 0) begin
            @(negedge clk);
            n++;
            if (ack === 1'b1) begin
                lat = n;
                rd  = dat_o;
                m_access(w, a, d, s, cycle_no, ex);
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string name, input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] rd, ex;
        int lat;
        wb(1'b1, BASE | 32'(off), d, s, rd, ex, lat);
        check({name, "_ack"}, lat, 1);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] off, input bit use_lit,
                          input logic [31:0] lit);
        logic [31:0] rd, ex;
        int lat;
        wb(1'b0, BASE | 32'(off), '0, 4'hF, rd, ex, lat);
        check({name, "_ack"}, lat, 1);
        check(name, rd, ex);
        if (use_lit) check({name, "_lit"}, rd, lit);
    endtask

    // Per-cycle comparison of the status outputs and DAC slice against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (cycle_no == m_start + W + 1) begin
                    m_result = m_pend;
                    m_done   = 1'b1;
                end
                if (done_o === 1'b1) done_seen++;
                check("mon_busy", busy_o, m_busy_at(cycle_no));
                check("mon_done", done_o, cycle_no == m_start + W + 1);
                check("mon_be_out", be_out, m_dac(m_result, m_slice));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] rd, ex;
        int lat, t, n, d0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_dat", dat_o, 0);
        check("rst_be", be_out, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        rst = 1'b0;

        // Unsigned maximum and latency.
        wr("u_opa", 8'h00, 32'h0000_FFFF, 4'h3);
        wr("u_opb", 8'h04, 32'h0000_FFFF, 4'h3);
        wr("u_start", 8'h08, 32'h0000_0001, 4'h1);
        check("u_busy_rise", busy_o, 1);
        t = 0;
        while (done_o !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("u_latency", t, 17);
        check("u_busy_fall", busy_o, 0);
        rd_chk("u_res_lo", 8'h10, 1, 32'hFFFE_0001);
        rd_chk("u_res_hi", 8'h14, 1, 32'h0);
        rd_chk("u_status", 8'h0C, 1, 32'h2);

        // Signed negative result and most-negative operands.
        wr("s_opa", 8'h00, 32'h0000_FFFD, 4'h3);
        wr("s_opb", 8'h04, 32'h0000_0005, 4'h3);
        wr("s_start", 8'h08, 32'h0000_0003, 4'h1);
        repeat (W + 4) @(negedge clk);
        rd_chk("s_res_lo", 8'h10, 1, 32'hFFFF_FFF1);
        rd_chk("s_ctrl", 8'h08, 1, 32'h2);
        wr("m_opa", 8'h00, 32'h0000_8000, 4'h3);
        wr("m_opb", 8'h04, 32'h0000_8000, 4'h3);
        wr("m_start", 8'h08, 32'h0000_0003, 4'h1);
        repeat (W + 4) @(negedge clk);
        rd_chk("m_res_lo", 8'h10, 1, 32'h4000_0000);
        rd_chk("m_res_hi", 8'h14, 1, 32'h0);

        // Busy protection: writes acked but ignored, one done pulse.
        d0 = done_seen;
        wr("b_opa", 8'h00, 32'h0000_0003, 4'h3);
        wr("b_opb", 8'h04, 32'h0000_0004, 4'h3);
        wr("b_start", 8'h08, 32'h0000_0001, 4'h1);
        wr("b_opa_busy", 8'h00, 32'h0000_00FF, 4'h3);
        wr("b_start_busy", 8'h08, 32'h0000_0001, 4'h1);
        rd_chk("b_res_prev", 8'h10, 1, 32'h4000_0000);
        repeat (2 * W + 8) @(negedge clk);
        check("b_done_pulses", done_seen - d0, 1);
        rd_chk("b_res_lo", 8'h10, 1, 32'h0000_000C);
        rd_chk("b_opa", 8'h00, 1, 32'h0000_0003);

        // Reset during the fifth RUN cycle.
        wr("r_opa", 8'h00, 32'h0000_1234, 4'h3);
        wr("r_opb", 8'h04, 32'h0000_0005, 4'h3);
        wr("r_start", 8'h08, 32'h0000_0001, 4'h1);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check("r_busy", busy_o, 0);
        check("r_be", be_out, 0);
        check("r_done", done_o, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        rd_chk("r_opa0", 8'h00, 1, 32'h0);
        rd_chk("r_opb0", 8'h04, 1, 32'h0);
        rd_chk("r_ctrl0", 8'h08, 1, 32'h0);
        rd_chk("r_status0", 8'h0C, 1, 32'h0);
        rd_chk("r_res0", 8'h10, 1, 32'h0);
        wr("r2_opa", 8'h00, 32'h0000_0002, 4'h3);
        wr("r2_opb", 8'h04, 32'h0000_0003, 4'h3);
        wr("r2_start", 8'h08, 32'h0000_0001, 4'h1);
        repeat (W + 4) @(negedge clk);
        rd_chk("r2_res_lo", 8'h10, 1, 32'h0000_0006);

        // Decode and ack behaviour.
        wb(1'b1, 32'h3000_0100, 32'h0000_FFFF, 4'hF, rd, ex, lat);
        check("d_noack", lat, -1);
        rd_chk("d_opa_kept", 8'h00, 1, 32'h0000_0002);
        wb(1'b0, 32'h3000_0020, '0, 4'hF, rd, ex, lat);
        check("d_gap_lat", lat, 1);
        check("d_gap_data", rd, 32'h0);
        wr("d_gap_wr", 8'h24, 32'hFFFF_FFFF, 4'hF);
        rd_chk("d_opb_kept", 8'h04, 1, 32'h0000_0003);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0020; sel = 4'hF;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack === 1'b1) n++;
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack === 1'b1) n++;
        end
        check("d_hold_acks", n, 1);

        // DAC slice and byte lanes.
        wr("c_opa", 8'h00, 32'h0000_003F, 4'h3);
        wr("c_opb", 8'h04, 32'h0000_0080, 4'h3);
        wr("c_start", 8'h08, 32'h0000_0701, 4'h3);
        repeat (W + 4) @(negedge clk);
        check("c_be_3f", be_out, 7'h3F);
        rd_chk("c_res_lo", 8'h10, 1, 32'h0000_1F80);
        wr("c_slice0", 8'h08, 32'h0000_0000, 4'h2);
        @(negedge clk);
        check("c_be_00", be_out, 7'h00);
        wr("c_lane", 8'h00, 32'h0000_AB00, 4'h2);
        rd_chk("c_opa_lane", 8'h00, 1, 32'h0000_AB3F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
